// File: rtl/riscv_dmem_ctrl_if.sv
// Data-bus interface between the data-memory controller (master) and memory (slave).
// Single req/ack transaction per access; bus_ack/bus_err are only meaningful while bus_req=1.
interface riscv_dmem_ctrl_if #(
    parameter int XLEN = 32
);
    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_adr;
    logic [3:0]      bus_be;
    logic [XLEN-1:0] bus_d;
    logic [XLEN-1:0] bus_q;
    logic            bus_ack;
    logic            bus_err;

    modport master (
        output bus_req, bus_we, bus_adr, bus_be, bus_d,
        input  bus_q, bus_ack, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_adr, bus_be, bus_d,
        output bus_q, bus_ack, bus_err
    );
endinterface

// File: rtl/riscv_dmem_ctrl.sv
// EX->MEM data-memory controller: alignment check, one bus transaction per access, load formatting.
// Optional bus timeout enabled by defining RISCV_DMEM_TIMEOUT_EN.
module riscv_dmem_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_req,
    input  logic               ex_we,
    input  logic [2:0]         ex_size,
    input  logic [XLEN-1:0]    ex_adr,
    input  logic [XLEN-1:0]    ex_d,
    input  logic               flush,
    output logic               dmem_stall,
    output logic [XLEN-1:0]    mem_q,
    output logic               mem_q_valid,
    output logic               mem_misaligned,
    output logic               mem_buserr,
    riscv_dmem_ctrl_if.master  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic            we_p1;
    logic [2:0]      size_p1;
    logic [1:0]      lane_p1;
    logic [XLEN-1:0] adr_p1;
    logic [3:0]      be_p1;
    logic [XLEN-1:0] d_p1;
    logic            kill_q;

    logic            aligned;
    logic            accept;
    logic            misalign;
    logic            busy;
    logic            done;
    logic            kill_eff;
    logic            timeout_hit;

    logic            bus_req_c;
    logic            bus_we_c;
    logic [3:0]      bus_be_c;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   is_aligned = 1'b1;
            2'b01:   is_aligned = ~lane[0];
            default: is_aligned = (lane == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   byte_enables = 4'b0001 << lane;
            2'b01:   byte_enables = 4'b0011 << lane;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [1:0] size, input logic [XLEN-1:0] d);
        case (size)
            2'b00:   store_data = {4{d[7:0]}};
            2'b01:   store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    // funct3[2] selects zero extension for the sub-word loads
    function automatic logic [XLEN-1:0] load_format(input logic [2:0] size, input logic [1:0] lane,
                                                    input logic [XLEN-1:0] q);
        logic [7:0]  b;
        logic [15:0] h;
        b = q[{lane, 3'b000} +: 8];
        h = lane[1] ? q[31:16] : q[15:0];
        case (size[1:0])
            2'b00:   load_format = size[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   load_format = size[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: load_format = q;
        endcase
    endfunction

    assign aligned  = is_aligned(ex_size[1:0], ex_adr[1:0]);
    assign accept   = (state_q == IDLE) && ex_req && !flush && aligned;
    assign misalign = (state_q == IDLE) && ex_req && !flush && !aligned;
    assign busy     = (state_q == BUSY);
    assign done     = busy && (bus.bus_ack || bus.bus_err || timeout_hit);
    // A flush arriving in the completion cycle kills that completion as well
    assign kill_eff = kill_q || flush;

`ifdef RISCV_DMEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (!busy) begin
            to_cnt <= '0;
        end else if (!bus.bus_ack && !bus.bus_err) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Fires in the BUSY cycle whose increment would reach TIMEOUT; ack/err in that cycle win
    assign timeout_hit = busy && !bus.bus_ack && !bus.bus_err && (to_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (done)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        dmem_stall = 1'b0;
        bus_req_c  = 1'b0;
        bus_we_c   = 1'b0;
        bus_be_c   = 4'b0000;
        case (state_q)
            IDLE: begin
                dmem_stall = accept;
            end
            BUSY: begin
                dmem_stall = 1'b1;
                bus_req_c  = 1'b1;
                bus_we_c   = we_p1;
                bus_be_c   = be_p1;
            end
            default: ;
        endcase
    end

    assign bus.bus_req = bus_req_c;
    assign bus.bus_we  = bus_we_c;
    assign bus.bus_be  = bus_be_c;
    assign bus.bus_adr = adr_p1;
    assign bus.bus_d   = d_p1;

    // Stage p1: request captured at accept, held stable for the whole bus transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            we_p1   <= 1'b0;
            size_p1 <= 3'b000;
            lane_p1 <= 2'b00;
            adr_p1  <= '0;
            be_p1   <= 4'b0000;
            d_p1    <= '0;
        end else if (accept) begin
            we_p1   <= ex_we;
            size_p1 <= ex_size;
            lane_p1 <= ex_adr[1:0];
            adr_p1  <= {ex_adr[XLEN-1:2], 2'b00};
            be_p1   <= byte_enables(ex_size[1:0], ex_adr[1:0]);
            d_p1    <= store_data(ex_size[1:0], ex_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kill_q <= 1'b0;
        end else if (done || !busy) begin
            kill_q <= 1'b0;
        end else if (flush) begin
            kill_q <= 1'b1;
        end
    end

    // Stage p2: completion results and event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q          <= '0;
            mem_q_valid    <= 1'b0;
            mem_misaligned <= 1'b0;
            mem_buserr     <= 1'b0;
        end else begin
            mem_q_valid    <= busy && bus.bus_ack && !bus.bus_err && !we_p1 && !kill_eff;
            mem_buserr     <= busy && (bus.bus_err || timeout_hit) && !kill_eff;
            mem_misaligned <= misalign;
            if (busy && bus.bus_ack && !bus.bus_err && !we_p1 && !kill_eff) begin
                mem_q <= load_format(size_p1, lane_p1, bus.bus_q);
            end
        end
    end

endmodule
